// File: rtl/ahb_si_resp_mux.sv
// AHB response multiplexer with a registered data-phase select and a built-in
// default slave that answers unmapped or multi-hot decodes with a two-cycle ERROR.
module ahb_si_resp_mux #(
  parameter int CHANNEL_NUM = 2,
  parameter int PAYLOAD     = 34,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [1:0]                     htrans,
  input  logic [CHANNEL_NUM-1:0]         sel_addr,
  input  logic [CHANNEL_NUM*PAYLOAD-1:0] payload_in,
  output logic [PAYLOAD-1:0]             payload_out,
  output logic [CHANNEL_NUM-1:0]         dsel,
  output logic [ERR_CNT_W-1:0]           err_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t                 state_q, state_d;
  logic [CHANNEL_NUM-1:0] dsel_q, dsel_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [PAYLOAD-1:0]     chan_masked [CHANNEL_NUM];
  logic [PAYLOAD-1:0]     data_mux;
  logic                   sel_any, sel_multi, hready;
  logic                   unused_htrans0;

  // Only htrans[1] separates real transfers from IDLE/BUSY.
  assign unused_htrans0 = htrans[0];

  // dsel_q is one-hot or zero, so an AND-OR mux selects exactly one channel.
  generate
    for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_mask
      assign chan_masked[gi] = payload_in[gi*PAYLOAD +: PAYLOAD] & {PAYLOAD{dsel_q[gi]}};
    end
  endgenerate

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      data_mux = data_mux | chan_masked[i];
    end
  end

  always_comb begin
    sel_any   = 1'b0;
    sel_multi = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (sel_addr[i]) begin
        if (sel_any) sel_multi = 1'b1;
        sel_any = 1'b1;
      end
    end
  end

  always_comb begin
    payload_out = PAYLOAD'(1);
    case (state_q)
      ST_IDLE: payload_out = PAYLOAD'(1);
      ST_DATA: payload_out = data_mux;
      ST_ERR1: payload_out = PAYLOAD'(2);
      ST_ERR2: payload_out = PAYLOAD'(3);
      default: payload_out = PAYLOAD'(1);
    endcase
  end

  assign hready = payload_out[0];

  always_comb begin
    state_d   = state_q;
    dsel_d    = dsel_q;
    err_cnt_d = err_cnt_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (hready) begin
      if (!htrans[1]) begin
        state_d = ST_IDLE;
        dsel_d  = '0;
      end else if (sel_any && !sel_multi) begin
        state_d = ST_DATA;
        dsel_d  = sel_addr;
      end else begin
        state_d = ST_ERR1;
        dsel_d  = '0;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      dsel_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dsel_q    <= dsel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign dsel    = dsel_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ahb_si_resp_mux.sv
// Randomised and directed scoreboard bench for ahb_si_resp_mux: stimulus pushes the
// expected response of each cycle, a negedge monitor pops and compares it.
module tb_ahb_si_resp_mux;

  localparam int CN = 2;
  localparam int PW = 34;
  localparam int EW = 2;
  localparam int CNT_MAX = (1 << EW) - 1;

  typedef struct packed {
    logic [PW-1:0] out;
    logic [CN-1:0] dsel;
    logic [EW-1:0] cnt;
  } exp_t;

  logic           HCLK = 1'b0;
  logic           HRESETn = 1'b1;
  logic [1:0]     htrans;
  logic [CN-1:0]  sel_addr;
  logic [PW-1:0]  p0, p1;
  logic [CN*PW-1:0] payload_in;
  logic [PW-1:0]  payload_out;
  logic [CN-1:0]  dsel;
  logic [EW-1:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  // Reference model: who owns the data phase, and how many error cycles remain.
  int owner    = -1;
  int err_left = 0;
  int cnt      = 0;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  mon_e;
  string mon_t;

  assign payload_in = {p1, p0};

  ahb_si_resp_mux #(.CHANNEL_NUM(CN), .PAYLOAD(PW), .ERR_CNT_W(EW)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .htrans(htrans),
    .sel_addr(sel_addr),
    .payload_in(payload_in),
    .payload_out(payload_out),
    .dsel(dsel),
    .err_cnt(err_cnt)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [31:0] d, input logic resp, input logic rdy);
    return {d, resp, rdy};
  endfunction

  function automatic logic [PW-1:0] rnd_pl();
    logic [31:0] d;
    logic resp, rdy;
    d    = $urandom();
    resp = ($urandom_range(0, 7) == 0);
    rdy  = ($urandom_range(0, 3) != 0);
    return mk(d, resp, rdy);
  endfunction

  task automatic model_reset();
    owner    = -1;
    err_left = 0;
    cnt      = 0;
  endtask

  // Advance the reference model by one rising edge.
  task automatic model_step(input logic [1:0] ht, input logic [CN-1:0] sa, input logic rdy);
    if (err_left == 2) begin
      err_left = 1;
    end else if (rdy) begin
      err_left = 0;
      owner    = -1;
      if (ht[1]) begin
        if ($countones(sa) == 1) begin
          for (int i = 0; i < CN; i++) if (sa[i]) owner = i;
        end else begin
          err_left = 2;
          if (cnt < CNT_MAX) cnt++;
        end
      end
    end
  endtask

  // Called just after a rising edge: drive one cycle, record expectation, step model.
  task automatic cycle(input logic [1:0] ht, input logic [CN-1:0] sa,
                       input logic [PW-1:0] a, input logic [PW-1:0] b, input string tag);
    exp_t e;
    logic [PW-1:0] chp[CN];
    htrans = ht; sel_addr = sa; p0 = a; p1 = b;
    chp[0] = a; chp[1] = b;
    e.out  = PW'(1);
    e.dsel = '0;
    e.cnt  = EW'(cnt);
    if (HRESETn) begin
      if (err_left == 2)      e.out = PW'(2);
      else if (err_left == 1) e.out = PW'(3);
      else if (owner >= 0) begin
        e.out  = chp[owner];
        e.dsel = CN'(1 << owner);
      end
    end else begin
      e.cnt = '0;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge HCLK);
    if (HRESETn) model_step(ht, sa, e.out[0]);
    #1;
  endtask

  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      txn++;
      $display("txn %0d %s: out=%h dsel=%b cnt=%0d", txn, mon_t, payload_out, dsel, err_cnt);
      chk({mon_t, ".payload_out"}, 64'(payload_out), 64'(mon_e.out));
      chk({mon_t, ".dsel"}, 64'(dsel), 64'(mon_e.dsel));
      chk({mon_t, ".err_cnt"}, 64'(err_cnt), 64'(mon_e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    htrans = 2'b00; sel_addr = '0; p0 = '0; p1 = '0;
    // Reset with no clock edge yet.
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_async.payload_out", 64'(payload_out), 64'(PW'(1)));
    chk("rst_async.dsel", 64'(dsel), 64'h0);
    chk("rst_async.err_cnt", 64'(err_cnt), 64'h0);
    @(posedge HCLK); #1;
    for (int i = 0; i < 3; i++)
      cycle(2'($urandom_range(0, 3)), CN'($urandom_range(0, 3)), rnd_pl(), rnd_pl(), "rst_hold");
    HRESETn = 1'b1;
    model_reset();

    // Single transfer with three wait states; htrans/sel_addr must be ignored meanwhile.
    cycle(2'b10, 2'b10, rnd_pl(), rnd_pl(), "w_addr");
    for (int i = 0; i < 3; i++)
      cycle(2'b10, 2'b00, rnd_pl(), mk($urandom(), 1'b0, 1'b0), "w_wait");
    cycle(2'b00, 2'b11, rnd_pl(), mk(32'hCAFE0001, 1'b0, 1'b1), "w_done");
    cycle(2'b00, 2'b00, rnd_pl(), rnd_pl(), "idle");

    // Back-to-back ch0 then ch1, no waits.
    cycle(2'b10, 2'b01, rnd_pl(), rnd_pl(), "b2b_a0");
    cycle(2'b11, 2'b10, mk(32'h1111AAAA, 1'b0, 1'b1), rnd_pl(), "b2b_d0");
    cycle(2'b00, 2'b00, rnd_pl(), mk(32'h2222BBBB, 1'b0, 1'b1), "b2b_d1");
    cycle(2'b00, 2'b00, rnd_pl(), rnd_pl(), "idle");

    // Decode errors: zero decode, then multi-hot.
    cycle(2'b10, 2'b00, rnd_pl(), rnd_pl(), "e_addr0");
    cycle(2'($urandom_range(0, 3)), CN'($urandom_range(0, 3)), rnd_pl(), rnd_pl(), "e_err1");
    cycle(2'b10, 2'b11, rnd_pl(), rnd_pl(), "e_addr11");
    cycle(2'($urandom_range(0, 3)), CN'($urandom_range(0, 3)), rnd_pl(), rnd_pl(), "e_err1");
    cycle(2'b00, 2'b00, rnd_pl(), rnd_pl(), "e_err2");
    cycle(2'b00, 2'b00, rnd_pl(), rnd_pl(), "idle");

    // Saturation: five more errors back to back.
    for (int i = 0; i < 5; i++) begin
      cycle(2'b10, 2'b00, rnd_pl(), rnd_pl(), "sat_addr");
      cycle(2'($urandom_range(0, 3)), CN'($urandom_range(0, 3)), rnd_pl(), rnd_pl(), "sat_err1");
    end
    cycle(2'b00, 2'b00, rnd_pl(), rnd_pl(), "sat_err2");
    cycle(2'b00, 2'b00, rnd_pl(), rnd_pl(), "idle");

    // IDLE/BUSY with multi-hot or random decode.
    for (int i = 0; i < 4; i++)
      cycle({1'b0, 1'(i)}, (i < 2) ? 2'b11 : CN'($urandom_range(0, 3)), rnd_pl(), rnd_pl(), "idle_busy");

    // Slave ERROR from channel 0 passes through unchanged.
    cycle(2'b10, 2'b01, rnd_pl(), rnd_pl(), "se_addr");
    cycle(2'b00, 2'b00, mk($urandom(), 1'b1, 1'b0), rnd_pl(), "se_err1");
    cycle(2'b00, 2'b00, mk($urandom(), 1'b1, 1'b1), rnd_pl(), "se_err2");
    cycle(2'b00, 2'b00, rnd_pl(), rnd_pl(), "idle");

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(2'($urandom_range(0, 3)), CN'($urandom_range(0, 3)), rnd_pl(), rnd_pl(), "rand");
    cycle(2'b00, 2'b00, mk($urandom(), 1'b0, 1'b1), mk($urandom(), 1'b0, 1'b1), "drain");
    cycle(2'b00, 2'b00, rnd_pl(), rnd_pl(), "idle");

    // Reset asserted mid-DATA: outputs go idle without an edge.
    cycle(2'b10, 2'b01, rnd_pl(), rnd_pl(), "rm_addr");
    p0 = mk(32'h5A5A0000, 1'b0, 1'b0);
    #1;
    chk("rm_data.payload_out", 64'(payload_out), 64'(p0));
    HRESETn = 1'b0;
    #1;
    chk("rm_rst.payload_out", 64'(payload_out), 64'(PW'(1)));
    chk("rm_rst.dsel", 64'(dsel), 64'h0);
    chk("rm_rst.err_cnt", 64'(err_cnt), 64'h0);
    model_reset();
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Reset asserted mid-ERR1.
    cycle(2'b10, 2'b11, rnd_pl(), rnd_pl(), "re_addr");
    #1;
    chk("re_err1.payload_out", 64'(payload_out), 64'(PW'(2)));
    chk("re_err1.err_cnt", 64'(err_cnt), 64'h1);
    HRESETn = 1'b0;
    #1;
    chk("re_rst.payload_out", 64'(payload_out), 64'(PW'(1)));
    chk("re_rst.err_cnt", 64'(err_cnt), 64'h0);
    model_reset();
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    cycle(2'b10, 2'b00, rnd_pl(), rnd_pl(), "post_addr");
    cycle(2'b00, 2'b00, rnd_pl(), rnd_pl(), "post_err1");
    cycle(2'b00, 2'b00, rnd_pl(), rnd_pl(), "post_err2");
    cycle(2'b00, 2'b00, rnd_pl(), rnd_pl(), "idle");

    @(posedge HCLK); #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_si_resp_mux.md
# ahb_si_resp_mux

Parametrised, registered-select AHB response multiplexer for the master-side slave interface. It replaces the purely combinational one-hot payload mux. The address-phase one-hot decode is captured into a data-phase select, so slave responses route correctly across wait states. Unmapped or invalid decodes produce a spec-compliant two-cycle ERROR response from a built-in default slave. It sits between the slave response channels and one master port of the generated interconnect.

## Interface
- CHANNEL_NUM, 2: number of slave response channels (≥1).
- PAYLOAD, 34: response payload width (≥3). Layout: bit0 = hreadyout, bit1 = hresp, bits [PAYLOAD-1:2] = hrdata.
- ERR_CNT_W, 8: width of the saturating decode-error counter.
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- htrans  in  2  address-phase HTRANS of the master.
- sel_addr  in  CHANNEL_NUM  address-phase one-hot decode, valid with htrans.
- payload_in  in  CHANNEL_NUM×PAYLOAD  per-channel slave response, same layout as payload_out.
- payload_out  out  PAYLOAD  muxed response to master; bit0 is also the bus HREADY.
- dsel  out  CHANNEL_NUM  registered data-phase select, one-hot or zero.
- err_cnt  out  ERR_CNT_W  count of decode errors, saturates at all-ones.

## Operation
- Address phase accepted on a rising edge when payload_out[0] (HREADY) = 1. No sampling while HREADY = 0.
- Accepted transfer classification:
  - htrans[1] = 0 (IDLE/BUSY): state IDLE, dsel = 0.
  - htrans[1] = 1 and sel_addr exactly one-hot: state DATA, dsel = sel_addr.
  - htrans[1] = 1 and sel_addr zero or multi-hot: state ERR1, dsel = 0, err_cnt += 1 unless saturated.
- State machine transitions:
  - IDLE: default OKAY response. payload_out = {hrdata 0, hresp 0, hready 1}.
  - DATA: payload_out = payload_in[index of dsel], combinational from payload_in. Unselected channels are fully ignored. Slave OKAY, wait and ERROR responses pass through unmodified. The state is held while the selected hreadyout = 0. When it is 1, the next address is accepted on that edge.
  - ERR1: payload_out = {0, hresp 1, hready 0}. Always goes to ERR2 next cycle.
  - ERR2: payload_out = {0, hresp 1, hready 1}. The next address is accepted on this edge, then classified normally.
- Back-to-back transfers: DATA → DATA to the same or a different channel with no idle cycle. dsel switches on the edge where the old channel completes.
- err_cnt is never cleared except by reset.

## Timing
- Reset (HRESETn = 0, asynchronous): state IDLE, dsel = 0, err_cnt = 0, payload_out = {0, 0, 1} immediately, with no clock required.
- Reset deassertion is synchronous to HCLK by the integrator. The first edge after deassertion samples the address phase.
- Reset mid-DATA or mid-ERR1 aborts at once: outputs return to IDLE values in the same cycle.
- Zero added latency in the data path: payload_in to payload_out is combinational once dsel is registered.
- Select latency is exactly one cycle: sel_addr at edge N → dsel valid after edge N.
- A decode error costs exactly 2 data-phase cycles (ERR1, ERR2) regardless of other inputs.
- sel_addr and htrans are ignored while HREADY = 0. Glitches or changes there have no effect.
- CHANNEL_NUM = 1: a one-hot check still applies, and sel_addr = 0 with htrans NONSEQ gives ERR1.

## Test plan
- Reset: hold HRESETn = 0 with random inputs → payload_out = 0x...001, dsel = 0, err_cnt = 0. Assert reset mid-DATA → outputs return to IDLE values without waiting for an edge.
- Single transfer with waits: NONSEQ, sel_addr = 2'b10. Channel 1 drives hready 0 for 3 cycles, then hrdata 0xCAFE0001 with hready 1. Result: dsel = 2'b10 for 4 cycles, payload_out tracks channel 1, channel 0 toggling is ignored, and the next address is sampled only on the 4th edge.
- Back-to-back: NONSEQ ch0 then SEQ ch1 with zero waits → dsel is 01 then 10 on consecutive cycles, and hrdata follows each channel in order.
- Decode error: NONSEQ with sel_addr = 0, then with sel_addr = 2'b11 → each gives ERR1 {hready 0, hresp 1} then ERR2 {hready 1, hresp 1}, and err_cnt goes 0→1→2.
- Saturation with ERR_CNT_W = 2: 5 decode errors → err_cnt sticks at 3.
- IDLE/BUSY with any sel_addr, including multi-hot → OKAY zero-wait, dsel = 0, no err_cnt change. A slave ERROR from channel 0 passes through unmodified, and err_cnt is unchanged.
